walksat_ctrl_responder: RTL and testbench
=========================================

# walksat_ctrl_responder

Datapath-side responder for the WalkSAT top-level controller's 14-bit control word. It accepts one control word per valid/ready handshake, decodes it into a datapath operation, runs that operation over several cycles, and returns a one-cycle response pulse. Operations are: evaluate snapshot, unsat count, unsat gather, random unsat-clause select, and clause/variable table read. It sits between the controller FSM and the clause/variable tables.

## Interface
- NUM_CLAUSES, 16: clauses per problem.
- IDX_W, 4: clause index width; must satisfy 2^IDX_W >= NUM_CLAUSES.
- CNT_W, 5: count width; must satisfy 2^CNT_W > NUM_CLAUSES.
- ADDR_W, 8: table address width.
- DATA_W, 32: table data width.
- MEM_LAT, 2: fixed table read latency in cycles, >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- ctrl_valid_i  in  1  control word valid.
- ctrl_word_i  in  14  control word.
- ctrl_ready_o  out  1  high only in IDLE.
- rsp_valid_o  out  1  one-cycle operation-complete pulse.
- rsp_err_o  out  1  qualified by rsp_valid_o; high = illegal word.
- clause_sat_i  in  NUM_CLAUSES  per-clause satisfied flags (1 = sat).
- rand_i  in  IDX_W  random value, sampled at accept.
- var_addr_i  in  ADDR_W  variable table address, sampled at accept.
- mem_rd_en_o  out  1  one-cycle read strobe.
- mem_rd_addr_o  out  ADDR_W  read address.
- mem_rd_data_i  in  DATA_W  read data, valid MEM_LAT cycles after the strobe.
- unsat_count_o  out  CNT_W  result of COUNT.
- sel_clause_o  out  IDX_W  selected unsat clause index.
- all_sat_o  out  1  high when SELECT found no unsat clause.
- rd_data_o  out  DATA_W  captured table data.

## Operation
Decode is an exact 14-bit match on the accepted word:
- 14'b10000000000001 SELECT: choose a clause from the gather buffer.
- 14'b00000000000010 SELECT_AGAIN: same behaviour as SELECT.
- 14'b00100000000000 READ_CLAUSE: read the clause table at address {0, sel_clause_o}.
- 14'b00001000000000 READ_VAR: read the variable table at the sampled var_addr_i.
- 14'b00000001100000 EVALUATE: snap <= clause_sat_i.
- 14'b00000000000000 COUNT: scan snap, one bit per cycle from index 0 upward, and count zero bits. unsat_count_o updates at the end of the scan.
- 14'b00000000000100 GATHER: clear the buffer write pointer gcnt, then scan snap. For each zero bit i, buf[gcnt] <= i and gcnt++. Buffer depth is NUM_CLAUSES, so it cannot overflow.
- Any other word: no operation; rsp_err_o=1.

SELECT and SELECT_AGAIN detail:
- If gcnt==0: all_sat_o=1 and sel_clause_o is unchanged.
- Otherwise: all_sat_o=0 and p=rand_i. While p>=gcnt, p<=p-gcnt, one subtraction per cycle. Then sel_clause_o<=buf[p].

FSM states and transitions:
- IDLE: on accept, go to the state for the decoded word.
- EVAL: go to RESP.
- SCAN_CNT / SCAN_GATH: go to RESP after the last index.
- REDUCE: go to RESP when p<gcnt or gcnt==0.
- MEM_ISSUE: go to MEM_WAIT.
- MEM_WAIT: capture rd_data_o after MEM_LAT cycles, then go to RESP.
- RESP: go to IDLE.
- Illegal word: IDLE -> RESP.

Handshake and hazards:
- Accept happens on a posedge with ctrl_valid_i & ctrl_ready_o.
- ctrl_valid_i while busy is ignored and not queued.
- COUNT and GATHER use the last snap, not the live clause_sat_i.

Arithmetic: all counters are unsigned. The scan index wraps to 0 only on return to IDLE.

## Timing
Reset (rst==0 at posedge):
- FSM goes to IDLE; snap, buf, gcnt and p are cleared.
- Outputs: ctrl_ready_o=1 in the cycle after reset; all other outputs 0.
- Reset wins over any simultaneous accept.
- Reset mid-operation aborts with no rsp_valid_o.

Latency, counted in cycles from the accept edge to the edge that raises rsp_valid_o:
- EVALUATE and illegal word: 2.
- COUNT and GATHER: NUM_CLAUSES+2.
- SELECT: 3+k, where k is the number of subtractions (0 when gcnt==0).
- READ: MEM_LAT+3. mem_rd_en_o is high for exactly one cycle, starting the cycle after accept.

Response:
- rsp_valid_o is high for exactly one cycle.
- Result outputs are stable from that cycle until the next operation updates them.
- ctrl_ready_o returns to 1 in the cycle after rsp_valid_o.
- Back-to-back accept is possible on that edge.

## Test plan
- EVALUATE with clause_sat_i=16'hFF0F, then COUNT -> unsat_count_o=4, rsp_valid_o 18 cycles after the COUNT accept, rsp_err_o=0.
- GATHER, then SELECT with rand_i=6 (gcnt=4, k=1) -> sel_clause_o=6, all_sat_o=0, rsp 4 cycles after accept. Then SELECT_AGAIN with rand_i=1 -> sel_clause_o=5.
- READ_CLAUSE after sel=6 with MEM_LAT=2 -> mem_rd_addr_o=8'h06 with a one-cycle strobe. Model returns 32'hDEADBEEF -> rd_data_o=32'hDEADBEEF, rsp at 5 cycles. READ_VAR with var_addr_i=8'h2A -> mem_rd_addr_o=8'h2A.
- EVALUATE 16'hFFFF, GATHER, SELECT -> all_sat_o=1, sel_clause_o unchanged.
- Illegal word 14'h3FFF -> rsp_err_o=1 with rsp_valid_o at 2 cycles, no mem_rd_en_o. ctrl_valid_i asserted during a COUNT scan -> ignored.
- rst=0 for one cycle, 5 cycles into COUNT -> no rsp_valid_o, all outputs 0, ctrl_ready_o=1. A following COUNT then returns unsat_count_o=16 (snap cleared to 0).

Source files
------------

// File: rtl/walksat_ctrl_responder.sv
// Datapath-side responder for the WalkSAT controller: accepts one 14-bit control word,
// runs the decoded snapshot/count/gather/select/table-read operation and pulses a response.
module walksat_ctrl_responder #(
    parameter int NUM_CLAUSES = 16,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 5,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_valid_i,
    input  logic [13:0]            ctrl_word_i,
    output logic                   ctrl_ready_o,
    output logic                   rsp_valid_o,
    output logic                   rsp_err_o,
    input  logic [NUM_CLAUSES-1:0] clause_sat_i,
    input  logic [IDX_W-1:0]       rand_i,
    input  logic [ADDR_W-1:0]      var_addr_i,
    output logic                   mem_rd_en_o,
    output logic [ADDR_W-1:0]      mem_rd_addr_o,
    input  logic [DATA_W-1:0]      mem_rd_data_i,
    output logic [CNT_W-1:0]       unsat_count_o,
    output logic [IDX_W-1:0]       sel_clause_o,
    output logic                   all_sat_o,
    output logic [DATA_W-1:0]      rd_data_o
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    localparam logic [13:0] W_SELECT       = 14'b10000000000001;
    localparam logic [13:0] W_SELECT_AGAIN = 14'b00000000000010;
    localparam logic [13:0] W_READ_CLAUSE  = 14'b00100000000000;
    localparam logic [13:0] W_READ_VAR     = 14'b00001000000000;
    localparam logic [13:0] W_EVALUATE     = 14'b00000001100000;
    localparam logic [13:0] W_COUNT        = 14'b00000000000000;
    localparam logic [13:0] W_GATHER       = 14'b00000000000100;

    localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(NUM_CLAUSES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EVAL,
        S_SCAN_CNT,
        S_SCAN_GATH,
        S_REDUCE,
        S_SEL_WR,
        S_MEM_ISSUE,
        S_MEM_WAIT,
        S_ILLEGAL,
        S_RESP
    } state_t;

    state_t                 state_r;
    logic [NUM_CLAUSES-1:0] snap_r;
    logic [IDX_W-1:0]       gath_buf_r [NUM_CLAUSES];
    logic [CNT_W-1:0]       gcnt_r;
    logic [CNT_W-1:0]       scan_idx_r;
    logic [CNT_W-1:0]       cnt_acc_r;
    logic [IDX_W-1:0]       p_r;
    logic [LAT_W-1:0]       wait_cnt_r;
    logic                   err_r;

    // Control FSM with all datapath state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            snap_r        <= '0;
            gcnt_r        <= '0;
            scan_idx_r    <= '0;
            cnt_acc_r     <= '0;
            p_r           <= '0;
            wait_cnt_r    <= '0;
            err_r         <= 1'b0;
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                gath_buf_r[i] <= '0;
            end
            ctrl_ready_o  <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            mem_rd_en_o   <= 1'b0;
            mem_rd_addr_o <= '0;
            unsat_count_o <= '0;
            sel_clause_o  <= '0;
            all_sat_o     <= 1'b0;
            rd_data_o     <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            mem_rd_en_o <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Ready rises one cycle after the response pulse, not with it.
                    ctrl_ready_o <= 1'b1;
                    scan_idx_r   <= '0;
                    wait_cnt_r   <= '0;
                    if (ctrl_valid_i && ctrl_ready_o) begin
                        ctrl_ready_o <= 1'b0;
                        case (ctrl_word_i)
                            W_SELECT, W_SELECT_AGAIN: begin
                                p_r     <= rand_i;
                                state_r <= S_REDUCE;
                            end
                            W_READ_CLAUSE: begin
                                mem_rd_en_o   <= 1'b1;
                                mem_rd_addr_o <= ADDR_W'(sel_clause_o);
                                state_r       <= S_MEM_ISSUE;
                            end
                            W_READ_VAR: begin
                                mem_rd_en_o   <= 1'b1;
                                mem_rd_addr_o <= var_addr_i;
                                state_r       <= S_MEM_ISSUE;
                            end
                            W_EVALUATE: begin
                                state_r <= S_EVAL;
                            end
                            W_COUNT: begin
                                cnt_acc_r <= '0;
                                state_r   <= S_SCAN_CNT;
                            end
                            W_GATHER: begin
                                gcnt_r  <= '0;
                                state_r <= S_SCAN_GATH;
                            end
                            default: begin
                                err_r   <= 1'b1;
                                state_r <= S_ILLEGAL;
                            end
                        endcase
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_EVAL: begin
                    snap_r  <= clause_sat_i;
                    state_r <= S_RESP;
                end
                S_SCAN_CNT: begin
                    if (scan_idx_r == SCAN_END) begin
                        unsat_count_o <= cnt_acc_r;
                        state_r       <= S_RESP;
                    end else begin
                        if (!snap_r[scan_idx_r[IDX_W-1:0]]) begin
                            cnt_acc_r <= cnt_acc_r + CNT_W'(1);
                        end
                        scan_idx_r <= scan_idx_r + CNT_W'(1);
                    end
                end
                S_SCAN_GATH: begin
                    if (scan_idx_r == SCAN_END) begin
                        state_r <= S_RESP;
                    end else begin
                        if (!snap_r[scan_idx_r[IDX_W-1:0]]) begin
                            gath_buf_r[gcnt_r[IDX_W-1:0]] <= scan_idx_r[IDX_W-1:0];
                            gcnt_r <= gcnt_r + CNT_W'(1);
                        end
                        scan_idx_r <= scan_idx_r + CNT_W'(1);
                    end
                end
                S_REDUCE: begin
                    // Modulo by repeated subtraction keeps the select index inside the buffer.
                    if ((gcnt_r != '0) && (CNT_W'(p_r) >= gcnt_r)) begin
                        p_r <= p_r - IDX_W'(gcnt_r);
                    end else begin
                        state_r <= S_SEL_WR;
                    end
                end
                S_SEL_WR: begin
                    if (gcnt_r == '0) begin
                        all_sat_o <= 1'b1;
                    end else begin
                        all_sat_o    <= 1'b0;
                        sel_clause_o <= gath_buf_r[p_r];
                    end
                    state_r <= S_RESP;
                end
                S_MEM_ISSUE: begin
                    state_r <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (wait_cnt_r == LAT_W'(MEM_LAT)) begin
                        rd_data_o <= mem_rd_data_i;
                        state_r   <= S_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + LAT_W'(1);
                    end
                end
                S_ILLEGAL: begin
                    state_r <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= err_r;
                    err_r       <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_walksat_ctrl_responder.sv
// Randomized self-checking bench: a cycle-level behavioural model predicts response timing
// and results from the operation rules; directed steps pin known values.
module tb_walksat_ctrl_responder;

    localparam int NC = 16, IW = 4, CW = 5, AW = 8, DW = 32, LAT = 2;

    localparam logic [13:0] W_SEL  = 14'b10000000000001;
    localparam logic [13:0] W_SELA = 14'b00000000000010;
    localparam logic [13:0] W_RDC  = 14'b00100000000000;
    localparam logic [13:0] W_RDV  = 14'b00001000000000;
    localparam logic [13:0] W_EVAL = 14'b00000001100000;
    localparam logic [13:0] W_CNT  = 14'b00000000000000;
    localparam logic [13:0] W_GATH = 14'b00000000000100;
    localparam logic [13:0] W_BAD  = 14'h3FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ctrl_valid_i = 1'b0;
    logic [13:0]   ctrl_word_i = 14'h0;
    logic          ctrl_ready_o, rsp_valid_o, rsp_err_o;
    logic [NC-1:0] clause_sat_i = '0;
    logic [IW-1:0] rand_i = '0;
    logic [AW-1:0] var_addr_i = '0;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [DW-1:0] mem_rd_data_i;
    logic [CW-1:0] unsat_count_o;
    logic [IW-1:0] sel_clause_o;
    logic          all_sat_o;
    logic [DW-1:0] rd_data_o;

    walksat_ctrl_responder #(
        .NUM_CLAUSES(NC), .IDX_W(IW), .CNT_W(CW), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_valid_i(ctrl_valid_i), .ctrl_word_i(ctrl_word_i), .ctrl_ready_o(ctrl_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
        .clause_sat_i(clause_sat_i), .rand_i(rand_i), .var_addr_i(var_addr_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .unsat_count_o(unsat_count_o), .sel_clause_o(sel_clause_o), .all_sat_o(all_sat_o),
        .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    // Table contents; address 6 holds 32'hDEADBEEF.
    function automatic logic [31:0] memf(input logic [7:0] a);
        return 32'hDEADBEEF ^ {4{a ^ 8'h06}};
    endfunction

    // Table model: data is valid only in a window starting MEM_LAT cycles after the strobe.
    int          mcnt = 0;
    logic [7:0]  maddr = 8'h00;
    always @(posedge clk) begin
        if (mem_rd_en_o) begin
            mcnt  <= 1;
            maddr <= mem_rd_addr_o;
        end else if (mcnt != 0 && mcnt < 100) begin
            mcnt <= mcnt + 1;
        end
    end
    assign mem_rd_data_i = (mcnt >= LAT && mcnt <= LAT + 1) ? memf(maddr) : 32'h0BAD0BAD;

    // ---------------- behavioural model ----------------
    logic [15:0] m_snap = '0;
    int          m_list[$];
    logic [3:0]  m_sel = '0;
    logic        m_all = 1'b0;
    logic [4:0]  m_cnt = '0;
    logic [31:0] m_rd = '0;
    logic        m_ready = 1'b1, m_rsp = 1'b0, m_rd_en = 1'b0, m_err = 1'b0;
    logic [7:0]  m_addr = '0;
    int          cd = 0;
    bit          rdy_pend = 0;
    logic [3:0]  p_sel;
    logic        p_all, p_err;
    logic [4:0]  p_cnt;
    logic [31:0] p_rd;
    bit          upd_sel, upd_cnt, upd_rd;
    int          cyc = 0;

    task automatic model_accept();
        int n;
        int r;
        upd_sel = 0; upd_cnt = 0; upd_rd = 0; p_err = 1'b0;
        case (ctrl_word_i)
            W_EVAL: begin m_snap = clause_sat_i; cd = 2; end
            W_CNT: begin
                n = 0;
                for (int i = 0; i < NC; i++) if (!m_snap[i]) n++;
                p_cnt = 5'(n); upd_cnt = 1; cd = NC + 2;
            end
            W_GATH: begin
                m_list.delete();
                for (int i = 0; i < NC; i++) if (!m_snap[i]) m_list.push_back(i);
                cd = NC + 2;
            end
            W_SEL, W_SELA: begin
                upd_sel = 1;
                r = int'(rand_i);
                if (m_list.size() == 0) begin
                    p_all = 1'b1; p_sel = m_sel; cd = 3;
                end else begin
                    p_all = 1'b0;
                    p_sel = 4'(m_list[r % m_list.size()]);
                    cd = 3 + r / m_list.size();
                end
            end
            W_RDC, W_RDV: begin
                m_addr = (ctrl_word_i == W_RDC) ? {4'h0, m_sel} : var_addr_i;
                m_rd_en = 1'b1;
                p_rd = memf(m_addr); upd_rd = 1;
                cd = LAT + 3;
            end
            default: begin p_err = 1'b1; cd = 2; end
        endcase
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_snap = '0; m_list.delete(); m_sel = '0; m_all = 1'b0; m_cnt = '0; m_rd = '0;
                m_ready = 1'b1; m_rsp = 1'b0; m_rd_en = 1'b0; m_err = 1'b0; cd = 0; rdy_pend = 0;
            end else begin
                m_rsp = 1'b0; m_rd_en = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_rsp = 1'b1; m_err = p_err; rdy_pend = 1;
                        if (upd_cnt) m_cnt = p_cnt;
                        if (upd_sel) begin m_sel = p_sel; m_all = p_all; end
                        if (upd_rd) m_rd = p_rd;
                    end
                end else if (rdy_pend) begin
                    rdy_pend = 0; m_ready = 1'b1;
                end else if (m_ready && ctrl_valid_i) begin
                    m_ready = 1'b0;
                    model_accept();
                end
            end
        end
    end

    // ---------------- compare process ----------------
    typedef struct { string name; logic [63:0] act; logic [63:0] exp; } pin_t;
    pin_t pins[$];
    int   checks = 0, errors = 0;
    bit   chk_en = 0;

    task automatic pin(input string n, input logic [63:0] a, input logic [63:0] e);
        pins.push_back('{n, a, e});
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    initial begin : compare
        pin_t pv;
        forever begin
            @(negedge clk);
            while (pins.size() > 0) begin
                pv = pins.pop_front();
                chk(pv.name, pv.act, pv.exp);
            end
            if (chk_en) begin
                chk("ctrl_ready", 64'(ctrl_ready_o), 64'(m_ready));
                chk("rsp_valid", 64'(rsp_valid_o), 64'(m_rsp));
                chk("mem_rd_en", 64'(mem_rd_en_o), 64'(m_rd_en));
                if (m_rd_en) chk("mem_rd_addr", 64'(mem_rd_addr_o), 64'(m_addr));
                if (m_rsp) chk("rsp_err", 64'(rsp_err_o), 64'(m_err));
                if (m_rsp || m_ready) begin
                    chk("unsat_count", 64'(unsat_count_o), 64'(m_cnt));
                    chk("sel_clause", 64'(sel_clause_o), 64'(m_sel));
                    chk("all_sat", 64'(all_sat_o), 64'(m_all));
                    chk("rd_data", 64'(rd_data_o), 64'(m_rd));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int acc_cyc = 0;
    int lat;

    task automatic issue(input logic [13:0] w, input logic [3:0] r, input logic [7:0] va);
        int t = 0;
        while (!ctrl_ready_o && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) pin("ready_timeout", 64'd0, 64'd1);
        ctrl_word_i = w; rand_i = r; var_addr_i = va; ctrl_valid_i = 1'b1;
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(output int l);
        l = -1;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid_o) begin l = cyc - acc_cyc; break; end
            @(negedge clk);
        end
        if (l < 0) pin("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        chk_en = 1;
        pin("reset_ready", 64'(ctrl_ready_o), 64'd1);
        pin("reset_outs", 64'({rsp_valid_o, rsp_err_o, mem_rd_en_o, mem_rd_addr_o,
                               unsat_count_o, sel_clause_o, all_sat_o}), 64'd0);
        pin("reset_rd_data", 64'(rd_data_o), 64'd0);

        clause_sat_i = 16'hFF0F;
        issue(W_EVAL, 4'd0, 8'h00); wait_rsp(lat);
        pin("eval_lat", 64'(lat), 64'd2);

        issue(W_CNT, 4'd0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            ctrl_valid_i = 1'b1; ctrl_word_i = W_BAD; @(negedge clk);
        end
        ctrl_valid_i = 1'b0;
        wait_rsp(lat);
        pin("count_lat", 64'(lat), 64'd18);
        pin("count_val", 64'(unsat_count_o), 64'd4);
        pin("count_err", 64'(rsp_err_o), 64'd0);

        issue(W_GATH, 4'd0, 8'h00); wait_rsp(lat);
        pin("gather_lat", 64'(lat), 64'd18);
        issue(W_SEL, 4'd6, 8'h00); wait_rsp(lat);
        pin("select_lat", 64'(lat), 64'd4);
        pin("select_val", 64'(sel_clause_o), 64'd6);
        pin("select_allsat", 64'(all_sat_o), 64'd0);
        issue(W_SELA, 4'd1, 8'h00); wait_rsp(lat);
        pin("select_again_val", 64'(sel_clause_o), 64'd5);
        pin("select_again_lat", 64'(lat), 64'd3);

        issue(W_SEL, 4'd6, 8'h00); wait_rsp(lat);
        issue(W_RDC, 4'd0, 8'h00); wait_rsp(lat);
        pin("read_clause_lat", 64'(lat), 64'd5);
        pin("read_clause_addr", 64'(mem_rd_addr_o), 64'h06);
        pin("read_clause_data", 64'(rd_data_o), 64'hDEADBEEF);
        issue(W_RDV, 4'd0, 8'h2A); wait_rsp(lat);
        pin("read_var_addr", 64'(mem_rd_addr_o), 64'h2A);

        clause_sat_i = 16'hFFFF;
        issue(W_SELA, 4'd1, 8'h00); wait_rsp(lat);
        issue(W_EVAL, 4'd0, 8'h00); wait_rsp(lat);
        issue(W_GATH, 4'd0, 8'h00); wait_rsp(lat);
        issue(W_SEL, 4'd9, 8'h00); wait_rsp(lat);
        pin("allsat_flag", 64'(all_sat_o), 64'd1);
        pin("allsat_sel_kept", 64'(sel_clause_o), 64'd5);
        pin("allsat_lat", 64'(lat), 64'd3);

        issue(W_BAD, 4'd0, 8'h00); wait_rsp(lat);
        pin("illegal_lat", 64'(lat), 64'd2);
        pin("illegal_err", 64'(rsp_err_o), 64'd1);

        issue(W_CNT, 4'd0, 8'h00);
        repeat (5) @(negedge clk);
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        pin("abort_ready", 64'(ctrl_ready_o), 64'd1);
        pin("abort_outs", 64'({rsp_valid_o, unsat_count_o, sel_clause_o, all_sat_o}), 64'd0);
        repeat (20) @(negedge clk);
        issue(W_CNT, 4'd0, 8'h00); wait_rsp(lat);
        pin("count_after_reset", 64'(unsat_count_o), 64'd16);

        ctrl_valid_i = 1'b1; ctrl_word_i = W_EVAL; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; ctrl_valid_i = 1'b0;
        pin("reset_beats_accept", 64'(ctrl_ready_o), 64'd1);
        repeat (4) @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            int k;
            logic [13:0] w;
            k = $urandom_range(0, 9);
            case (k)
                0, 1: begin
                    case ($urandom_range(0, 3))
                        0: clause_sat_i = 16'($urandom);
                        1: clause_sat_i = 16'hFFFF;
                        2: clause_sat_i = 16'($urandom | $urandom | $urandom);
                        default: clause_sat_i = 16'($urandom & $urandom);
                    endcase
                    w = W_EVAL;
                end
                2: w = W_CNT;
                3: w = W_GATH;
                4: w = W_SEL;
                5: w = W_SELA;
                6: w = W_RDC;
                7: w = W_RDV;
                default: w = 14'($urandom);
            endcase
            issue(w, 4'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                ctrl_valid_i = 1'b1; ctrl_word_i = 14'($urandom);
                @(negedge clk);
                ctrl_valid_i = 1'b0;
            end
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                rst = 1'b0; @(negedge clk); rst = 1'b1;
            end else begin
                wait_rsp(lat);
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
